dec_stage_1: RTL and testbench

- Pipelined extended-Hamming (SECDED) decoder, the receive-side counterpart of the encode stage.
- Accepts a codeword of mode 1 (8,4), mode 2 (16,11) or mode 3 (32,26), selected per word by work_mod.
- Computes the syndrome and overall parity, corrects a single-bit error, flags double errors, and returns the info bits.
- Sits between the AMBA register block and the output FIFO, with a valid/ready handshake and saturating error counters.

---
 rtl/dec_stage_1.sv | 200 ++++++++++++++++++++
 tb/tb_dec_stage_1.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_stage_1.sv
// Two-stage pipelined extended-Hamming (SECDED) decoder for (8,4), (16,11) and (32,26) codewords.
// Stage 1 forms syndrome and overall parity; stage 2 corrects/classifies and feeds saturating error counters.
module dec_stage_1 #(
    parameter int AMBA_WORD          = 32,
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int MAX_INFO_WIDTH     = 26,
    parameter int CNT_W              = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MAX_CODEWORD_WIDTH-1:0] codeword_in,
    input  logic [AMBA_WORD-1:0]          work_mod,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MAX_INFO_WIDTH-1:0]     data_out,
    output logic [1:0]                    num_of_errors,
    input  logic                          cnt_clr,
    output logic [CNT_W-1:0]              corr_cnt,
    output logic [CNT_W-1:0]              uncorr_cnt
);
    localparam logic [4:0][25:0] ROWS = {
        26'b11111111111111100000000000,
        26'b11111111000000011111110000,
        26'b11110000111100011110001110,
        26'b11001100110011011001101101,
        26'b10101010101010110101011011
    };
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [31:0] w_cw;
    logic [1:0]  w_mode;
    logic [25:0] w_info;
    logic [4:0]  w_par;
    logic [4:0]  w_row_mask;
    logic        w_p_all;
    logic [4:0]  w_syn_raw;
    logic [4:0]  w_syn;
    logic        w_s2_adv;
    logic        w_in_ready;
    logic        w_out_fire;
    logic [25:0] w_hit;
    logic        w_unit;
    logic [25:0] w_data_next;
    logic [1:0]  w_num_next;

    logic                      r_s1_valid;
    logic [1:0]                r_s1_mode;
    logic [25:0]               r_s1_info;
    logic [4:0]                r_s1_syn;
    logic                      r_s1_p;
    logic                      r_out_valid;
    logic [MAX_INFO_WIDTH-1:0] r_data;
    logic [1:0]                r_num;
    logic [CNT_W-1:0]          r_corr;
    logic [CNT_W-1:0]          r_uncorr;

    assign w_cw = 32'(codeword_in);

    // Modes whose codeword does not fit the configured input width decode as invalid.
    always_comb begin
        w_mode = 2'd3;
        if (work_mod == AMBA_WORD'(0) && MAX_CODEWORD_WIDTH >= 8)
            w_mode = 2'd0;
        else if (work_mod == AMBA_WORD'(1) && MAX_CODEWORD_WIDTH >= 16)
            w_mode = 2'd1;
        else if (work_mod == AMBA_WORD'(2) && MAX_CODEWORD_WIDTH >= 32)
            w_mode = 2'd2;
    end

    always_comb begin
        w_info     = '0;
        w_par      = '0;
        w_p_all    = 1'b0;
        w_row_mask = '0;
        case (w_mode)
            2'd0: begin
                w_info     = {22'b0, w_cw[7:4]};
                w_par      = {2'b0, w_cw[2:0]};
                w_p_all    = ^w_cw[7:0];
                w_row_mask = 5'b00111;
            end
            2'd1: begin
                w_info     = {15'b0, w_cw[15:5]};
                w_par      = {1'b0, w_cw[3:0]};
                w_p_all    = ^w_cw[15:0];
                w_row_mask = 5'b01111;
            end
            2'd2: begin
                w_info     = w_cw[31:6];
                w_par      = w_cw[4:0];
                w_p_all    = ^w_cw;
                w_row_mask = 5'b11111;
            end
            default: ;
        endcase
    end

    // Info is zero-padded above k, so full-width row masks reduce to the mode's columns.
    genvar gi;
    for (gi = 0; gi < 5; gi++) begin : g_syn
        assign w_syn_raw[gi] = (^(w_info & ROWS[gi])) ^ w_par[gi];
    end
    assign w_syn = w_syn_raw & w_row_mask;

    assign w_s2_adv   = !r_out_valid || out_ready;
    assign w_in_ready = !r_s1_valid || w_s2_adv;
    assign w_out_fire = r_out_valid && out_ready;

    for (gi = 0; gi < 26; gi++) begin : g_col
        localparam logic [4:0] C3  = {ROWS[4][gi], ROWS[3][gi], ROWS[2][gi], ROWS[1][gi], ROWS[0][gi]};
        localparam logic [4:0] C2  = {1'b0, C3[3:0]};
        localparam logic [4:0] C1  = {2'b00, C3[2:0]};
        localparam bit         IN2 = (gi < 11);
        localparam bit         IN1 = (gi < 4);
        assign w_hit[gi] = (r_s1_mode == 2'd2 && r_s1_syn == C3)
                        || (IN2 && r_s1_mode == 2'd1 && r_s1_syn == C2)
                        || (IN1 && r_s1_mode == 2'd0 && r_s1_syn == C1);
    end

    assign w_unit = (r_s1_syn != 5'd0) && ((r_s1_syn & (r_s1_syn - 5'd1)) == 5'd0);

    always_comb begin
        w_data_next = r_s1_info;
        w_num_next  = 2'd0;
        if (r_s1_mode == 2'd3) begin
            w_data_next = '0;
            w_num_next  = 2'd3;
        end else if (r_s1_syn == 5'd0) begin
            w_num_next = r_s1_p ? 2'd1 : 2'd0;
        end else if (r_s1_p) begin
            if (|w_hit) begin
                w_data_next = r_s1_info ^ w_hit;
                w_num_next  = 2'd1;
            end else if (w_unit) begin
                w_num_next = 2'd1;
            end else begin
                w_num_next = 2'd2;
            end
        end else begin
            w_num_next = 2'd2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s1_mode  <= 2'd0;
            r_s1_info  <= '0;
            r_s1_syn   <= '0;
            r_s1_p     <= 1'b0;
        end else begin
            if (w_in_ready)
                r_s1_valid <= in_valid;
            if (in_valid && w_in_ready) begin
                r_s1_mode <= w_mode;
                r_s1_info <= w_info;
                r_s1_syn  <= w_syn;
                r_s1_p    <= w_p_all;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_data      <= '0;
            r_num       <= 2'd0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_data <= w_data_next[MAX_INFO_WIDTH-1:0];
                r_num  <= w_num_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_corr   <= '0;
            r_uncorr <= '0;
        end else if (cnt_clr) begin
            r_corr   <= '0;
            r_uncorr <= '0;
        end else if (w_out_fire) begin
            if (r_num == 2'd1 && r_corr != CNT_MAX)
                r_corr <= r_corr + CNT_W'(1);
            if (r_num == 2'd2 && r_uncorr != CNT_MAX)
                r_uncorr <= r_uncorr + CNT_W'(1);
        end
    end

    assign in_ready      = w_in_ready;
    assign out_valid     = r_out_valid;
    assign data_out      = r_data;
    assign num_of_errors = r_num;
    assign corr_cnt      = r_corr;
    assign uncorr_cnt    = r_uncorr;
endmodule

// File: tb/tb_dec_stage_1.sv
// Scoreboard bench for dec_stage_1: expected {num, data} pushed on acceptance, popped on output handshake.
module tb_dec_stage_1;
    localparam int CNT_W = 2;
    localparam logic [4:0][25:0] ROWS = {
        26'b11111111111111100000000000,
        26'b11111111000000011111110000,
        26'b11110000111100011110001110,
        26'b11001100110011011001101101,
        26'b10101010101010110101011011
    };

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      codeword_in = '0;
    logic [31:0]      work_mod = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [25:0]      data_out;
    logic [1:0]       num_of_errors;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] corr_cnt;
    logic [CNT_W-1:0] uncorr_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [27:0] sb_q[$];

    dec_stage_1 #(.AMBA_WORD(32), .MAX_CODEWORD_WIDTH(32), .MAX_INFO_WIDTH(26), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .codeword_in(codeword_in), .work_mod(work_mod), .out_valid(out_valid),
        .out_ready(out_ready), .data_out(data_out), .num_of_errors(num_of_errors),
        .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    function automatic int kb(input int m);
        return (m == 0) ? 4 : (m == 1) ? 11 : 26;
    endfunction

    function automatic int pb(input int m);
        return (m == 0) ? 4 : (m == 1) ? 5 : 6;
    endfunction

    function automatic logic [25:0] kmask(input int m);
        logic [25:0] one;
        one = 26'd1;
        return (one << kb(m)) - 26'd1;
    endfunction

    function automatic logic [31:0] encode(input int m, input logic [25:0] d);
        logic [5:0]  p;
        logic [31:0] cw;
        p = '0;
        if (m == 0) begin
            for (int j = 0; j < 3; j++) p[j] = ^(d[3:0] & ROWS[j][3:0]);
            p[3] = ^{d[3:0], p[2:0]};
            cw = {24'b0, d[3:0], p[3:0]};
        end else if (m == 1) begin
            for (int j = 0; j < 4; j++) p[j] = ^(d[10:0] & ROWS[j][10:0]);
            p[4] = ^{d[10:0], p[3:0]};
            cw = {16'b0, d[10:0], p[4:0]};
        end else begin
            for (int j = 0; j < 5; j++) p[j] = ^(d & ROWS[j]);
            p[5] = ^{d, p[4:0]};
            cw = {d, p};
        end
        return cw;
    endfunction

    // Output monitor: one line per delivered word, compared against the scoreboard head.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            logic [27:0] exp_v;
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output got num=%0d data=%h, none expected", num_of_errors, data_out);
            end else begin
                exp_v = sb_q.pop_front();
                $display("OUT num=%0d data=%h exp num=%0d data=%h", num_of_errors, data_out, exp_v[27:26], exp_v[25:0]);
                if ({num_of_errors, data_out} !== exp_v) begin
                    n_fail++;
                    $display("FAIL output got num=%0d data=%h exp num=%0d data=%h",
                             num_of_errors, data_out, exp_v[27:26], exp_v[25:0]);
                end
            end
        end
    end

    task automatic send(input logic [31:0] cw, input logic [31:0] wm, input logic [27:0] exp_v);
        bit ok;
        codeword_in = cw;
        work_mod    = wm;
        in_valid    = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL send_accept got in_ready=0 for 50 cycles, exp accept of cw=%h", cw);
        end else begin
            sb_q.push_back(exp_v);
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 100 && sb_q.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d words pending, exp 0", sb_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string name, input logic [CNT_W-1:0] exp_c, input logic [CNT_W-1:0] exp_u);
        n_checks++;
        if (corr_cnt !== exp_c || uncorr_cnt !== exp_u) begin
            n_fail++;
            $display("FAIL %s got corr=%0d uncorr=%0d exp corr=%0d uncorr=%0d", name, corr_cnt, uncorr_cnt, exp_c, exp_u);
        end
    endtask

    task automatic clear_counters();
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        check_cnt("cnt_clr", 0, 0);
    endtask

    task automatic single_error(input int m, output logic [31:0] cw, output logic [27:0] exp_v);
        logic [25:0] d;
        d = 26'($urandom()) & kmask(m);
        cw = encode(m, d) ^ (32'd1 << $urandom_range(0, kb(m) + pb(m) - 1));
        exp_v = {2'd1, d};
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if (out_valid !== 1'b0 || data_out !== '0 || num_of_errors !== 2'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state got ov=%b data=%h num=%0d ir=%b exp 0 0 0 1", out_valid, data_out, num_of_errors, in_ready);
        end
        check_cnt("reset_counters", 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_mode1();
        send(32'h0000_00B1, 32'd0, {2'd0, 26'hB});
        send(32'h0000_0091, 32'd0, {2'd1, 26'hB});
        drain();
        check_cnt("mode1_counters", 1, 0);
        send(32'h0000_0081, 32'd0, {2'd2, 26'h8});
        send(32'h0000_00B9, 32'd0, {2'd1, 26'hB});
        drain();
        check_cnt("mode1_double_counters", 2, 1);
    endtask

    task automatic test_mode3();
        send(32'h8000_0000, 32'd2, {2'd1, 26'h0});
        send(32'h0000_0000, 32'd2, {2'd0, 26'h0});
        drain();
        check_cnt("mode3_counters", 3, 1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] cw;
        logic [27:0] exp_v;
        clear_counters();
        for (int m = 0; m < 3; m++) begin
            single_error(m, cw, exp_v);
            send(cw, 32'(m), exp_v);
        end
        send(32'h1234_5678, 32'd3, {2'd3, 26'h0});
        send(32'h0000_00B1, 32'hFFFF_FFFF, {2'd3, 26'h0});
        drain();
        check_cnt("alternating_counters", 3, 0);
        for (int m = 0; m < 3; m++) begin
            logic [25:0] d;
            logic [31:0] sh;
            int n, b1, b2;
            n  = kb(m) + pb(m);
            d  = 26'($urandom()) & kmask(m);
            b1 = $urandom_range(0, n - 1);
            b2 = (b1 + $urandom_range(1, n - 1)) % n;
            cw = encode(m, d) ^ (32'd1 << b1) ^ (32'd1 << b2);
            sh = cw >> pb(m);
            send(cw, 32'(m), {2'd2, sh[25:0] & kmask(m)});
        end
        drain();
        check_cnt("double_counters", 3, 3);
    endtask

    task automatic test_saturation();
        logic [31:0] cw;
        logic [27:0] exp_v;
        clear_counters();
        for (int i = 0; i < 5; i++) begin
            single_error(i % 3, cw, exp_v);
            send(cw, 32'(i % 3), exp_v);
        end
        drain();
        check_cnt("saturation", 3, 0);
    endtask

    task automatic test_clr_concurrent();
        logic [31:0] cw;
        logic [27:0] exp_v;
        bit seen;
        out_ready = 1'b0;
        single_error(2, cw, exp_v);
        send(cw, 32'd2, exp_v);
        in_valid = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(posedge clk);
            #1;
            seen = out_valid;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL clr_wait got out_valid=0 for 10 cycles, exp 1");
        end
        out_ready = 1'b1;
        cnt_clr   = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr   = 1'b0;
        check_cnt("clr_vs_increment", 0, 0);
        drain();
    endtask

    task automatic test_backpressure();
        logic [31:0] cw[5];
        logic [27:0] ev[5];
        for (int i = 0; i < 5; i++) single_error(1, cw[i], ev[i]);
        out_ready = 1'b0;
        send(cw[0], 32'd1, ev[0]);
        send(cw[1], 32'd1, ev[1]);
        codeword_in = cw[2];
        in_valid    = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || {num_of_errors, data_out} !== sb_q[0]) begin
                n_fail++;
                $display("FAIL stall_hold cyc=%0d got ir=%b ov=%b num=%0d data=%h exp ir=0 ov=1 num=%0d data=%h",
                         c, in_ready, out_valid, num_of_errors, data_out, sb_q[0][27:26], sb_q[0][25:0]);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        for (int i = 2; i < 5; i++) send(cw[i], 32'd1, ev[i]);
        drain();
        check_cnt("backpressure_counters", 3, 0);
    endtask

    task automatic test_reset_inflight();
        logic [31:0] cw;
        logic [27:0] exp_v;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            single_error(0, cw, exp_v);
            send(cw, 32'd0, exp_v);
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || data_out !== '0 || num_of_errors !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_inflight got ov=%b data=%h num=%0d exp 0 0 0", out_valid, data_out, num_of_errors);
        end
        check_cnt("reset_inflight_counters", 0, 0);
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stale_after_reset cyc=%0d got ov=%b ir=%b exp ov=0 ir=1", c, out_valid, in_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mode1();
        test_mode3();
        test_back_to_back();
        test_saturation();
        test_clr_concurrent();
        test_backpressure();
        test_reset_inflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
